// File: rtl/register_map_mp.sv
// Multi-ported architectural register map: committed data, latest producer tag and ready bit per register.
// Optional macro REGMAP_SIM_TP_EN adds o_sim_tp, a live copy of register SIM_TP_REG's data.
module register_map_mp #(
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int REG_DEPTH    = 32,
    parameter int RENAME_PORTS = 2,
    parameter int RETIRE_PORTS = 2,
    parameter int SIM_TP_REG   = 4
) (
    input  logic                                        clk,
    input  logic                                        n_rst,
    input  logic                                        i_flush,
    input  logic [RETIRE_PORTS-1:0]                     i_retire_en,
    input  logic [RETIRE_PORTS*$clog2(REG_DEPTH)-1:0]   i_retire_rdest,
    input  logic [RETIRE_PORTS*TAG_WIDTH-1:0]           i_retire_tag,
    input  logic [RETIRE_PORTS*DATA_WIDTH-1:0]          i_retire_data,
    input  logic [RENAME_PORTS-1:0]                     i_rename_en,
    input  logic [RENAME_PORTS*$clog2(REG_DEPTH)-1:0]   i_rename_rdest,
    input  logic [RENAME_PORTS*TAG_WIDTH-1:0]           i_rename_tag,
    input  logic                                        i_lookup_valid,
    input  logic [2*RENAME_PORTS*$clog2(REG_DEPTH)-1:0] i_lookup_rsrc,
    output logic                                        o_lookup_valid,
    output logic [2*RENAME_PORTS-1:0]                   o_lookup_rdy,
    output logic [2*RENAME_PORTS*TAG_WIDTH-1:0]         o_lookup_tag,
    output logic [2*RENAME_PORTS*DATA_WIDTH-1:0]        o_lookup_data
`ifdef REGMAP_SIM_TP_EN
    ,
    output logic [DATA_WIDTH-1:0]                       o_sim_tp
`endif
);

    localparam int IDX_W = $clog2(REG_DEPTH);
    localparam int SRC_N = 2 * RENAME_PORTS;

    logic [DATA_WIDTH-1:0] reg_data [REG_DEPTH];
    logic [TAG_WIDTH-1:0]  reg_tag  [REG_DEPTH];
    logic [REG_DEPTH-1:0]  reg_rdy;

    logic [SRC_N-1:0]            lk_rdy;
    logic [SRC_N*TAG_WIDTH-1:0]  lk_tag;
    logic [SRC_N*DATA_WIDTH-1:0] lk_data;

    // Entry 0 is never written, so it keeps its reset values (data 0, tag 0, ready).
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                reg_data[i] <= '0;
                reg_tag[i]  <= '0;
            end
            reg_rdy <= '1;
        end else begin
            for (int p = 0; p < RETIRE_PORTS; p++) begin
                if (i_retire_en[p] && i_retire_rdest[p*IDX_W +: IDX_W] != '0)
                    reg_data[i_retire_rdest[p*IDX_W +: IDX_W]] <= i_retire_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
            if (i_flush) begin
                reg_rdy <= '1;
            end else begin
                for (int p = 0; p < RETIRE_PORTS; p++) begin
                    if (i_retire_en[p] && i_retire_rdest[p*IDX_W +: IDX_W] != '0 &&
                        i_retire_tag[p*TAG_WIDTH +: TAG_WIDTH] == reg_tag[i_retire_rdest[p*IDX_W +: IDX_W]])
                        reg_rdy[i_retire_rdest[p*IDX_W +: IDX_W]] <= 1'b1;
                end
                // Renames come last so they beat retires, and younger ports beat older ones.
                for (int p = 0; p < RENAME_PORTS; p++) begin
                    if (i_rename_en[p] && i_rename_rdest[p*IDX_W +: IDX_W] != '0) begin
                        reg_tag[i_rename_rdest[p*IDX_W +: IDX_W]] <= i_rename_tag[p*TAG_WIDTH +: TAG_WIDTH];
                        reg_rdy[i_rename_rdest[p*IDX_W +: IDX_W]] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        logic [IDX_W-1:0]      src;
        logic                  rdy_v;
        logic [TAG_WIDTH-1:0]  tag_v;
        logic [DATA_WIDTH-1:0] data_v;
        lk_rdy  = '0;
        lk_tag  = '0;
        lk_data = '0;
        src     = '0;
        rdy_v   = 1'b0;
        tag_v   = '0;
        data_v  = '0;
        for (int s = 0; s < SRC_N; s++) begin
            src    = i_lookup_rsrc[s*IDX_W +: IDX_W];
            rdy_v  = reg_rdy[src];
            tag_v  = reg_tag[src];
            data_v = reg_data[src];
            if (!reg_rdy[src]) begin
                for (int p = 0; p < RETIRE_PORTS; p++) begin
                    if (i_retire_en[p] && i_retire_rdest[p*IDX_W +: IDX_W] == src &&
                        i_retire_tag[p*TAG_WIDTH +: TAG_WIDTH] == reg_tag[src]) begin
                        rdy_v  = 1'b1;
                        data_v = i_retire_data[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            // Only renames from ports older than this slot's owner forward into it.
            for (int j = 0; j < RENAME_PORTS; j++) begin
                if (j < s / 2 && i_rename_en[j] && src != '0 &&
                    i_rename_rdest[j*IDX_W +: IDX_W] == src) begin
                    rdy_v = 1'b0;
                    tag_v = i_rename_tag[j*TAG_WIDTH +: TAG_WIDTH];
                end
            end
            lk_rdy[s]                          = rdy_v;
            lk_tag[s*TAG_WIDTH +: TAG_WIDTH]    = tag_v;
            lk_data[s*DATA_WIDTH +: DATA_WIDTH] = data_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            o_lookup_valid <= 1'b0;
            o_lookup_rdy   <= '0;
            o_lookup_tag   <= '0;
            o_lookup_data  <= '0;
        end else begin
            o_lookup_valid <= i_lookup_valid;
            if (i_lookup_valid) begin
                o_lookup_rdy  <= lk_rdy;
                o_lookup_tag  <= lk_tag;
                o_lookup_data <= lk_data;
            end
        end
    end

`ifdef REGMAP_SIM_TP_EN
    assign o_sim_tp = reg_data[SIM_TP_REG];
`endif

endmodule

// File: tb/tb_register_map_mp.sv
// Directed bench for register_map_mp: rename, retire, bypass, intra-bundle forwarding, flush, r0 and reset.
module tb_register_map_mp;

    localparam int DW = 32;
    localparam int TW = 6;
    localparam int IW = 5;
    localparam int RN = 2;
    localparam int RT = 2;
    localparam int SN = 2 * RN;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              i_flush;
    logic [RT-1:0]     i_retire_en;
    logic [RT*IW-1:0]  i_retire_rdest;
    logic [RT*TW-1:0]  i_retire_tag;
    logic [RT*DW-1:0]  i_retire_data;
    logic [RN-1:0]     i_rename_en;
    logic [RN*IW-1:0]  i_rename_rdest;
    logic [RN*TW-1:0]  i_rename_tag;
    logic              i_lookup_valid;
    logic [SN*IW-1:0]  i_lookup_rsrc;
    logic              o_lookup_valid;
    logic [SN-1:0]     o_lookup_rdy;
    logic [SN*TW-1:0]  o_lookup_tag;
    logic [SN*DW-1:0]  o_lookup_data;

    int vectors = 0;
    int miscompares = 0;

    register_map_mp dut (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
        .i_retire_en(i_retire_en), .i_retire_rdest(i_retire_rdest),
        .i_retire_tag(i_retire_tag), .i_retire_data(i_retire_data),
        .i_rename_en(i_rename_en), .i_rename_rdest(i_rename_rdest), .i_rename_tag(i_rename_tag),
        .i_lookup_valid(i_lookup_valid), .i_lookup_rsrc(i_lookup_rsrc),
        .o_lookup_valid(o_lookup_valid), .o_lookup_rdy(o_lookup_rdy),
        .o_lookup_tag(o_lookup_tag), .o_lookup_data(o_lookup_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_flush = 0; i_retire_en = '0; i_retire_rdest = '0; i_retire_tag = '0; i_retire_data = '0;
        i_rename_en = '0; i_rename_rdest = '0; i_rename_tag = '0;
        i_lookup_valid = 0; i_lookup_rsrc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename(input int p, input logic [IW-1:0] rd, input logic [TW-1:0] tg);
        i_rename_en[p] = 1'b1;
        i_rename_rdest[p*IW +: IW] = rd;
        i_rename_tag[p*TW +: TW] = tg;
    endtask

    task automatic retire(input int p, input logic [IW-1:0] rd, input logic [TW-1:0] tg, input logic [DW-1:0] d);
        i_retire_en[p] = 1'b1;
        i_retire_rdest[p*IW +: IW] = rd;
        i_retire_tag[p*TW +: TW] = tg;
        i_retire_data[p*DW +: DW] = d;
    endtask

    task automatic lookup(input int s, input logic [IW-1:0] rd);
        i_lookup_valid = 1'b1;
        i_lookup_rsrc[s*IW +: IW] = rd;
    endtask

    function automatic logic [TW-1:0] tag_of(input int s);
        return o_lookup_tag[s*TW +: TW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int s);
        return o_lookup_data[s*DW +: DW];
    endfunction

    initial begin
        idle();
        n_rst = 0;
        #1;
        step();
        step();
        check("reset_valid", o_lookup_valid, 0);
        check("reset_rdy", o_lookup_rdy, 0);
        check("reset_tag", o_lookup_tag, 0);
        check("reset_data", o_lookup_data, 0);
        n_rst = 1;

        // Fresh lookup of r5 and r0
        lookup(0, 5); lookup(1, 0);
        step();
        check("fresh_valid", o_lookup_valid, 1);
        check("fresh_r5_rdy", o_lookup_rdy[0], 1);
        check("fresh_r5_data", data_of(0), 0);
        check("fresh_r0_rdy", o_lookup_rdy[1], 1);
        check("fresh_r0_data", data_of(1), 0);

        // Rename r3/7, then retire with same-cycle lookup (bypass)
        rename(0, 3, 7);
        step();
        retire(0, 3, 7, 32'hABCD); lookup(0, 3);
        step();
        check("bypass_rdy", o_lookup_rdy[0], 1);
        check("bypass_data", data_of(0), 32'hABCD);
        lookup(0, 3);
        step();
        check("stored_rdy", o_lookup_rdy[0], 1);
        check("stored_data", data_of(0), 32'hABCD);
        step();
        check("hold_valid", o_lookup_valid, 0);
        check("hold_data", data_of(0), 32'hABCD);

        // Same-register renames in one bundle; slot2 belongs to port1
        rename(0, 3, 2); rename(1, 3, 9); lookup(0, 3); lookup(2, 3);
        step();
        check("own_port_rdy", o_lookup_rdy[0], 1);
        check("own_port_data", data_of(0), 32'hABCD);
        check("intra_rdy", o_lookup_rdy[2], 0);
        check("intra_tag", tag_of(2), 2);
        retire(0, 3, 2, 32'h55); lookup(0, 3);
        step();
        check("stale_retire_rdy", o_lookup_rdy[0], 0);
        check("stale_retire_tag", tag_of(0), 9);
        lookup(0, 3);
        step();
        check("young_tag_rdy", o_lookup_rdy[0], 0);
        check("young_tag_tag", tag_of(0), 9);

        // Retire and rename of r6 in the same cycle
        rename(0, 6, 5); retire(0, 6, 4, 32'h66);
        step();
        lookup(0, 6);
        step();
        check("ren_ret_rdy", o_lookup_rdy[0], 0);
        check("ren_ret_tag", tag_of(0), 5);

        // Flush with renames in flight plus an ignored rename of r7
        rename(0, 1, 10); rename(1, 2, 11);
        step();
        i_flush = 1; rename(0, 7, 12);
        step();
        lookup(0, 1); lookup(1, 2); lookup(2, 7); lookup(3, 6);
        step();
        check("flush_rdy", o_lookup_rdy, 4'hF);
        check("flush_r1_tag", tag_of(0), 10);
        check("flush_r2_tag", tag_of(1), 11);
        check("flush_r7_tag", tag_of(2), 0);
        check("flush_r6_data", data_of(3), 32'h66);

        // Two retires to r8, then retire/rename of r0
        retire(0, 8, 0, 32'h11); retire(1, 8, 0, 32'h22);
        step();
        retire(0, 0, 0, 32'hFF); rename(1, 0, 3);
        step();
        lookup(0, 8); lookup(1, 0); lookup(3, 0); rename(0, 0, 1);
        step();
        check("dual_retire_data", data_of(0), 32'h22);
        check("r0_rdy", o_lookup_rdy[1], 1);
        check("r0_data", data_of(1), 0);
        check("r0_tag", tag_of(1), 0);
        check("r0_no_fwd_rdy", o_lookup_rdy[3], 1);

        // Reset mid-operation overrides a concurrent rename and retire
        rename(0, 9, 1); retire(0, 8, 0, 32'h99); lookup(0, 8);
        n_rst = 0;
        step();
        n_rst = 1;
        check("midrst_valid", o_lookup_valid, 0);
        lookup(0, 9); lookup(1, 8);
        step();
        check("midrst_r9_rdy", o_lookup_rdy[0], 1);
        check("midrst_r9_tag", tag_of(0), 0);
        check("midrst_r8_data", data_of(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
